// File: rtl/tx_pattern_gen_if.sv
// tx_pattern_gen_if: TX word handshake between the pattern source and the FT245 core.
// The master drives the data word and the write strobe. The slave reports readiness.
interface tx_pattern_gen_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_write;
    logic                  tx_ready;

    modport master (output tx_data, output tx_write, input tx_ready);
    modport slave  (input tx_data, input tx_write, output tx_ready);
endinterface

// File: rtl/tx_pattern_gen.sv
// tx_pattern_gen: backpressure-aware burst pattern source for the FT245 TX path.
// A rising edge on the synchronised trigger starts a burst of burst_len words.
// The pattern is counter, walking-one, LFSR or constant. The burst stalls while tx_ready is low.
// Optional feature macro: TX_PATTERN_LFSR_EN builds the LFSR pattern for mode 2.
// When the macro is undefined, mode 2 falls back to the counter pattern and no LFSR logic exists.
module tx_pattern_gen #(
    parameter int          DATA_WIDTH = 32,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] CONST_WORD = 32'hA5A5_5A5A,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 trigger,
    input  logic                 stop,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] burst_len,
    tx_pattern_gen_if.master     tx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    typedef enum logic [1:0] {
        PAT_COUNT = 2'd0,
        PAT_WALK  = 2'd1,
        PAT_LFSR  = 2'd2,
        PAT_CONST = 2'd3
    } pattern_t;

    state_t                state_q;
    pattern_t              mode_q;
    pattern_t              mode_eff;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_start;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  sync_1;
    logic                  sync_2;
    logic                  trig_d;
    logic                  start;
    logic                  start_accept;
    logic                  tx_write;
    logic                  is_last;

    // Bring the asynchronous trigger into clk_in and keep a delayed copy for edge detection.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            trig_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its pre-edge input;
            // blocking ones would collapse this chain into a single stage.
            sync_1 <= trigger;
            sync_2 <= sync_1;
            trig_d <= sync_2;
        end
    end

    assign start        = sync_2 & ~trig_d;
    assign start_accept = start && (state_q == ST_IDLE);

    // A zero-length burst passes through RUN without ever presenting a word.
    assign tx_write     = (state_q == ST_RUN) && (len_q != '0) && tx.tx_ready;
    assign is_last      = (word_cnt == len_q - CNT_WIDTH'(1));
    assign tx.tx_write  = tx_write;
    assign tx.tx_data   = data_q;

`ifdef TX_PATTERN_LFSR_EN
    assign mode_eff = pattern_t'(mode);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_next;

    assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

    // The LFSR restarts from the seed at each start and steps once per accepted LFSR word.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lfsr_q <= LFSR_SEED;
        end else if (start_accept) begin
            lfsr_q <= LFSR_SEED;
        end else if (tx_write && (mode_q == PAT_LFSR)) begin
            lfsr_q <= lfsr_next;
        end
    end
`else
    // Without the LFSR, mode 2 is treated as the counter pattern when it is latched.
    assign mode_eff = (mode == PAT_LFSR) ? PAT_COUNT : pattern_t'(mode);
`endif

    // Select the first word of a burst from the mode that is sampled at the start edge.
    always_comb begin
        // NOTE: the default assignment first covers every path, so no latch can be inferred.
        data_start = '0;
        case (mode_eff)
            PAT_WALK:  data_start = DATA_WIDTH'(1);
            PAT_CONST: data_start = CONST_WORD[DATA_WIDTH-1:0];
`ifdef TX_PATTERN_LFSR_EN
            PAT_LFSR:  data_start = LFSR_SEED[DATA_WIDTH-1:0];
`endif
            default:   data_start = '0;
        endcase
    end

    // Compute the word that follows the current one for the latched pattern.
    always_comb begin
        data_next = data_q + DATA_WIDTH'(1);
        case (mode_q)
            PAT_WALK:  data_next = {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
            PAT_CONST: data_next = CONST_WORD[DATA_WIDTH-1:0];
`ifdef TX_PATTERN_LFSR_EN
            PAT_LFSR:  data_next = lfsr_next[DATA_WIDTH-1:0];
`endif
            default:   data_next = data_q + DATA_WIDTH'(1);
        endcase
    end

    // The output word loads at start and advances only on an accepted write.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_q <= '0;
        end else if (start_accept) begin
            data_q <= data_start;
        end else if (tx_write) begin
            data_q <= data_next;
        end
    end

    // Burst control FSM: it sequences IDLE, RUN and DONE, counts words, and registers busy and done.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            mode_q   <= PAT_COUNT;
            len_q    <= '0;
            word_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tx_write) begin
                word_cnt <= word_cnt + CNT_WIDTH'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_RUN;
                        mode_q   <= mode_eff;
                        len_q    <= burst_len;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // An abort wins over completion. A write in the same cycle still counts.
                    if (stop) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if ((len_q == '0) || (tx_write && is_last)) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// tb_tx_pattern_gen: drives a 32-bit and an 8-bit tx_pattern_gen from shared stimulus.
// Both instances are compared against a word-index reference model of the patterns.
`timescale 1ns/1ps
module tb_tx_pattern_gen;
    localparam int          CW         = 16;
    localparam logic [31:0] CONST_WORD = 32'hA5A5_5A5A;
    localparam logic [31:0] LFSR_SEED  = 32'h0000_0001;

    logic          clk_in    = 1'b0;
    logic          rst_in    = 1'b0;
    logic          trigger   = 1'b0;
    logic          stop      = 1'b0;
    logic          ready     = 1'b0;
    logic [1:0]    mode      = 2'd0;
    logic [CW-1:0] burst_len = '0;
    logic          busy32, done32, busy8, done8;
    logic [CW-1:0] cnt32, cnt8;

    int n_cmp = 0;
    int n_bad = 0;

    tx_pattern_gen_if #(.DATA_WIDTH(32)) if32 ();
    tx_pattern_gen_if #(.DATA_WIDTH(8))  if8 ();
    assign if32.tx_ready = ready;
    assign if8.tx_ready  = ready;

    tx_pattern_gen #(.DATA_WIDTH(32), .CNT_WIDTH(CW), .CONST_WORD(CONST_WORD), .LFSR_SEED(LFSR_SEED)) dut32 (
        .clk_in(clk_in), .rst_in(rst_in), .trigger(trigger), .stop(stop), .mode(mode),
        .burst_len(burst_len), .tx(if32), .busy(busy32), .done(done32), .word_cnt(cnt32));

    tx_pattern_gen #(.DATA_WIDTH(8), .CNT_WIDTH(CW), .CONST_WORD(CONST_WORD), .LFSR_SEED(LFSR_SEED)) dut8 (
        .clk_in(clk_in), .rst_in(rst_in), .trigger(trigger), .stop(stop), .mode(mode),
        .burst_len(burst_len), .tx(if8), .busy(busy8), .done(done8), .word_cnt(cnt8));

    always #5 clk_in = ~clk_in;

    // Reference model: word n of a burst in mode m at width w, derived from the pattern rules.
    function automatic logic [31:0] model_word(input int m, input int n, input int w);
        logic [31:0] mask;
        logic [31:0] l;
        int          eff;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        eff  = m;
`ifndef TX_PATTERN_LFSR_EN
        if (eff == 2) eff = 0;
`endif
        case (eff)
            0: return 32'(n) & mask;
            1: return 32'd1 << (n % w);
            2: begin
                l = LFSR_SEED;
                for (int i = 0; i < n; i++) l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
                return l & mask;
            end
            default: return CONST_WORD & mask;
        endcase
    endfunction

    // Observations collected by run_cycles.
    logic [31:0] q32[$];
    logic [31:0] q8[$];
    int done_cnt, first_wr, last_wr, done_at, stall_chg, wr_no_rdy, busy_after_stop;

    // Drives one observation window and records writes, done pulses and stall behaviour.
    task automatic run_cycles(input int ncyc, input int rdy_sel, input int stop_at,
                              input int trig_a, input int trig_b, input bit scramble);
        logic [31:0] prev_d;
        logic        prev_w, prev_busy, stop_prev;
        logic [6:0]  bp;
        int          rc;
        bp = 7'b1011001;
        q32.delete(); q8.delete();
        done_cnt = 0; first_wr = -1; last_wr = -1; done_at = -1;
        stall_chg = 0; wr_no_rdy = 0; busy_after_stop = -1;
        prev_d = '0; prev_w = 1'b0; prev_busy = 1'b0; stop_prev = 1'b0; rc = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk_in); #1;
            if (c == trig_a || c == trig_b) trigger = 1'b1;
            else if (c == trig_a + 3 || c == trig_b + 3) trigger = 1'b0;
            if (scramble && c == trig_a + 6) begin
                mode      = 2'($urandom_range(0, 3));
                burst_len = CW'($urandom_range(0, 200));
            end
            case (rdy_sel)
                0:       ready = 1'b1;
                1:       ready = ($urandom_range(0, 3) != 0);
                default: ready = bp[rc % 7];
            endcase
            stop = (stop_at >= 0) && busy32 && (q32.size() == stop_at - 1);
            if (stop) ready = 1'b1;
            if (busy32) rc++;
            @(negedge clk_in);
            if (stop_prev) busy_after_stop = int'(busy32);
            if (if32.tx_write && !ready) wr_no_rdy++;
            if (busy32 && prev_busy && !prev_w && (if32.tx_data !== prev_d)) stall_chg++;
            if (if32.tx_write) begin
                q32.push_back(if32.tx_data);
                if (first_wr < 0) first_wr = c;
                last_wr = c;
            end
            if (if8.tx_write) q8.push_back(32'(if8.tx_data));
            if (done32) begin done_cnt++; done_at = c; end
            prev_w = if32.tx_write; prev_busy = busy32; prev_d = if32.tx_data; stop_prev = stop;
        end
        stop = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        ready = 1'b1;
        #1;
        n_cmp++; if (if32.tx_write !== 1'b0) begin n_bad++; $display("FAIL reset_tx_write: got %0b expected 0", if32.tx_write); end
        n_cmp++; if (busy32 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", busy32); end
        n_cmp++; if (done32 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b expected 0", done32); end
        n_cmp++; if (cnt32 !== '0) begin n_bad++; $display("FAIL reset_word_cnt: got %0d expected 0", cnt32); end
        n_cmp++; if (if32.tx_data !== 32'd0) begin n_bad++; $display("FAIL reset_tx_data32: got %0h expected 0", if32.tx_data); end
        n_cmp++; if (if8.tx_data !== 8'd0) begin n_bad++; $display("FAIL reset_tx_data8: got %0h expected 0", if8.tx_data); end
        // stop while idle must not change anything
        @(posedge clk_in); #1; stop = 1'b1;
        repeat (3) @(posedge clk_in);
        #1; stop = 1'b0;
        n_cmp++; if (busy32 !== 1'b0) begin n_bad++; $display("FAIL idle_stop_busy: got %0b expected 0", busy32); end
        n_cmp++; if (cnt32 !== '0) begin n_bad++; $display("FAIL idle_stop_word_cnt: got %0d expected 0", cnt32); end
    endtask

    task automatic test_start_latency();
        mode = 2'd0; burst_len = CW'(2); ready = 1'b1;
        @(posedge clk_in); #1; trigger = 1'b1;
        @(posedge clk_in); #1;
        n_cmp++; if (busy32 !== 1'b0) begin n_bad++; $display("FAIL latency_busy_k: got %0b expected 0", busy32); end
        @(posedge clk_in); #1;
        n_cmp++; if (busy32 !== 1'b0) begin n_bad++; $display("FAIL latency_busy_k1: got %0b expected 0", busy32); end
        @(posedge clk_in); #1;
        n_cmp++; if (busy32 !== 1'b1) begin n_bad++; $display("FAIL latency_busy_k2: got %0b expected 1", busy32); end
        @(negedge clk_in);
        n_cmp++; if (if32.tx_write !== 1'b1) begin n_bad++; $display("FAIL latency_first_write: got %0b expected 1", if32.tx_write); end
        n_cmp++; if (if32.tx_data !== 32'd0) begin n_bad++; $display("FAIL latency_first_data: got %0h expected 0", if32.tx_data); end
        trigger = 1'b0;
        run_cycles(10, 0, -1, -1, -1, 1'b0);
    endtask

    task automatic test_counter_burst();
        mode = 2'd0; burst_len = CW'(8);
        run_cycles(30, 0, -1, 0, -1, 1'b0);
        n_cmp++; if (q32.size() !== 8) begin n_bad++; $display("FAIL counter_writes32: got %0d expected 8", q32.size()); end
        n_cmp++; if (q8.size() !== 8) begin n_bad++; $display("FAIL counter_writes8: got %0d expected 8", q8.size()); end
        for (int i = 0; i < q32.size(); i++) begin
            n_cmp++; if (q32[i] !== model_word(0, i, 32)) begin n_bad++; $display("FAIL counter_data[%0d]: got %0h expected %0h", i, q32[i], model_word(0, i, 32)); end
        end
        n_cmp++; if (last_wr - first_wr !== 7) begin n_bad++; $display("FAIL counter_no_bubbles: got span %0d expected 7", last_wr - first_wr); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL counter_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_at - last_wr !== 1) begin n_bad++; $display("FAIL counter_done_timing: got %0d expected 1", done_at - last_wr); end
        n_cmp++; if (cnt32 !== CW'(8)) begin n_bad++; $display("FAIL counter_word_cnt: got %0d expected 8", cnt32); end
        n_cmp++; if (busy32 !== 1'b0) begin n_bad++; $display("FAIL counter_busy_end: got %0b expected 0", busy32); end
    endtask

    task automatic test_backpressure();
        mode = 2'd0; burst_len = CW'(4);
        run_cycles(30, 2, -1, 0, -1, 1'b0);
        n_cmp++; if (q32.size() !== 4) begin n_bad++; $display("FAIL bp_writes: got %0d expected 4", q32.size()); end
        for (int i = 0; i < q32.size(); i++) begin
            n_cmp++; if (q32[i] !== model_word(0, i, 32)) begin n_bad++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, q32[i], model_word(0, i, 32)); end
        end
        n_cmp++; if (wr_no_rdy !== 0) begin n_bad++; $display("FAIL bp_write_without_ready: got %0d expected 0", wr_no_rdy); end
        n_cmp++; if (stall_chg !== 0) begin n_bad++; $display("FAIL bp_data_hold: got %0d changes expected 0", stall_chg); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (cnt32 !== CW'(4)) begin n_bad++; $display("FAIL bp_word_cnt: got %0d expected 4", cnt32); end
    endtask

    task automatic test_patterns();
        int m, len;
        // walking-one 10, constant 6, LFSR 3, then random bursts with random backpressure
        for (int t = 0; t < 9; t++) begin
            case (t)
                0: begin m = 1; len = 10; end
                1: begin m = 3; len = 6; end
                2: begin m = 2; len = 3; end
                default: begin m = $urandom_range(0, 3); len = $urandom_range(1, 24); end
            endcase
            mode = 2'(m); burst_len = CW'(len);
            run_cycles(4 * len + 20, 1, -1, 0, -1, 1'b0);
            n_cmp++; if (q32.size() !== len) begin n_bad++; $display("FAIL pat%0d_writes32: got %0d expected %0d", t, q32.size(), len); end
            n_cmp++; if (q8.size() !== len) begin n_bad++; $display("FAIL pat%0d_writes8: got %0d expected %0d", t, q8.size(), len); end
            for (int i = 0; i < q32.size(); i++) begin
                n_cmp++; if (q32[i] !== model_word(m, i, 32)) begin n_bad++; $display("FAIL pat%0d_m%0d_data32[%0d]: got %0h expected %0h", t, m, i, q32[i], model_word(m, i, 32)); end
            end
            for (int i = 0; i < q8.size(); i++) begin
                n_cmp++; if (q8[i] !== model_word(m, i, 8)) begin n_bad++; $display("FAIL pat%0d_m%0d_data8[%0d]: got %0h expected %0h", t, m, i, q8[i], model_word(m, i, 8)); end
            end
            n_cmp++; if (stall_chg !== 0) begin n_bad++; $display("FAIL pat%0d_data_hold: got %0d changes expected 0", t, stall_chg); end
            n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL pat%0d_done_count: got %0d expected 1", t, done_cnt); end
            n_cmp++; if (cnt8 !== CW'(len)) begin n_bad++; $display("FAIL pat%0d_word_cnt8: got %0d expected %0d", t, cnt8, len); end
        end
    endtask

    task automatic test_abort();
        mode = 2'd0; burst_len = CW'(100);
        run_cycles(30, 0, 5, 0, -1, 1'b0);
        n_cmp++; if (cnt32 !== CW'(5)) begin n_bad++; $display("FAIL abort_word_cnt: got %0d expected 5", cnt32); end
        n_cmp++; if (q32.size() !== 5) begin n_bad++; $display("FAIL abort_writes: got %0d expected 5", q32.size()); end
        n_cmp++; if (busy_after_stop !== 0) begin n_bad++; $display("FAIL abort_idle_next: got busy %0d expected 0", busy_after_stop); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
        burst_len = CW'(6);
        run_cycles(30, 0, 6, 0, -1, 1'b0);
        n_cmp++; if (cnt32 !== CW'(6)) begin n_bad++; $display("FAIL abort_last_word_cnt: got %0d expected 6", cnt32); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_last_no_done: got %0d expected 0", done_cnt); end
        n_cmp++; if (busy_after_stop !== 0) begin n_bad++; $display("FAIL abort_last_idle_next: got busy %0d expected 0", busy_after_stop); end
    endtask

    task automatic test_zero_len();
        mode = 2'd1; burst_len = '0;
        run_cycles(20, 0, -1, 0, -1, 1'b0);
        n_cmp++; if (q32.size() !== 0) begin n_bad++; $display("FAIL zero_len_writes: got %0d expected 0", q32.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zero_len_done: got %0d expected 1", done_cnt); end
        n_cmp++; if (cnt32 !== '0) begin n_bad++; $display("FAIL zero_len_word_cnt: got %0d expected 0", cnt32); end
        n_cmp++; if (busy32 !== 1'b0) begin n_bad++; $display("FAIL zero_len_busy_end: got %0b expected 0", busy32); end
    endtask

    task automatic test_back_to_back();
        int m;
        m = $urandom_range(0, 3);
        mode = 2'(m); burst_len = CW'(12);
        // a second trigger and changed mode/length arrive mid-burst and must be ignored
        run_cycles(80, 1, -1, 0, 8, 1'b1);
        n_cmp++; if (q32.size() !== 12) begin n_bad++; $display("FAIL retrig_writes: got %0d expected 12", q32.size()); end
        for (int i = 0; i < q32.size(); i++) begin
            n_cmp++; if (q32[i] !== model_word(m, i, 32)) begin n_bad++; $display("FAIL retrig_m%0d_data[%0d]: got %0h expected %0h", m, i, q32[i], model_word(m, i, 32)); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL retrig_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (cnt32 !== CW'(12)) begin n_bad++; $display("FAIL retrig_word_cnt: got %0d expected 12", cnt32); end
    endtask

    task automatic test_reset_mid_burst();
        mode = 2'd0; burst_len = CW'(50);
        run_cycles(10, 0, -1, 0, -1, 1'b0);
        @(posedge clk_in); #3; rst_in = 1'b0; ready = 1'b1;
        #1;
        n_cmp++; if (busy32 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %0b expected 0", busy32); end
        n_cmp++; if (if32.tx_write !== 1'b0) begin n_bad++; $display("FAIL rst_mid_tx_write: got %0b expected 0", if32.tx_write); end
        n_cmp++; if (cnt32 !== '0) begin n_bad++; $display("FAIL rst_mid_word_cnt: got %0d expected 0", cnt32); end
        n_cmp++; if (if32.tx_data !== 32'd0) begin n_bad++; $display("FAIL rst_mid_tx_data: got %0h expected 0", if32.tx_data); end
        n_cmp++; if (done32 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done: got %0b expected 0", done32); end
        repeat (2) @(posedge clk_in);
        #1; rst_in = 1'b1;
        run_cycles(70, 0, -1, -1, -1, 1'b0);
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d expected 0", done_cnt); end
        n_cmp++; if (q32.size() !== 0) begin n_bad++; $display("FAIL rst_mid_no_writes: got %0d expected 0", q32.size()); end
    endtask

    initial begin
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1; rst_in = 1'b1;
        test_reset();
        test_start_latency();
        test_counter_burst();
        test_backpressure();
        test_patterns();
        test_abort();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
